vex_issue_sched: RTL

- Sequences vector micro-ops from the vector issue queue into the vector execution stage.
- Shares that stage's single writeback port between latency classes:
  - integer, 1 cycle
  - reduction, 3 cycles
  - mul/div, 4 cycles
  - floating-point, variable and blocking
- Resolves writeback-slot collisions and RAW/WAW register hazards.
- Predicts the writeback address and provides a drain handshake for fences and CSR writes.

---
 rtl/vex_issue_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vex_issue_sched.sv
// Vector issue scheduler: feeds uops to the vector execution stage and
// shares its single writeback port through a latency reservation table.
module vex_issue_sched #(
    parameter int VECTOR_REGISTERS = 32,
    parameter int LAT_INT          = 1,
    parameter int LAT_RDC          = 3,
    parameter int LAT_MULDIV       = 4,
    parameter int MAX_LAT          = 4,
    localparam int AW = $clog2(VECTOR_REGISTERS),
    localparam int SW = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uop_valid_i,
    output logic          uop_ready_o,
    input  logic [1:0]    uop_class_i,
    input  logic [AW-1:0] uop_dst_i,
    input  logic [AW-1:0] uop_src1_i,
    input  logic [AW-1:0] uop_src2_i,
    input  logic [1:0]    uop_src_use_i,
    output logic          vex_valid_o,
    input  logic          vex_ready_i,
    input  logic          vex_idle_i,
    input  logic          fp_done_i,
    output logic          wb_valid_o,
    output logic [AW-1:0] wb_addr_o,
    input  logic          drain_req_i,
    output logic          drain_ack_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {RUN, FP_WAIT, DRAIN, DRAINED} state_t;

    state_t        state, state_nxt;
    logic [MAX_LAT:0] res_v;
    logic [AW-1:0] res_d [MAX_LAT+1];
    logic [AW-1:0] fp_dst;
    logic [SW-1:0] lat;
    logic [SW-1:0] slot;
    logic          is_fp;
    logic          any_v;
    logic          hz_struct;
    logic          hz_raw;
    logic          hz_waw;
    logic          hazard;
    logic          accept;

    always_comb begin
        is_fp = 1'b0;
        lat   = SW'(LAT_INT);
        unique case (uop_class_i)
            2'd0:    lat = SW'(LAT_INT);
            2'd1:    lat = SW'(LAT_RDC);
            2'd2:    lat = SW'(LAT_MULDIV);
            default: is_fp = 1'b1;
        endcase
    end

    assign slot  = lat - SW'(1);
    assign any_v = |res_v;

    always_comb begin
        hz_raw = 1'b0;
        hz_waw = 1'b0;
        for (int k = 0; k <= MAX_LAT; k++) begin
            if (res_v[k]) begin
                if (uop_src_use_i[0] && uop_src1_i == res_d[k]) hz_raw = 1'b1;
                if (uop_src_use_i[1] && uop_src2_i == res_d[k]) hz_raw = 1'b1;
                if (uop_dst_i == res_d[k]) hz_waw = 1'b1;
            end
        end
        if (state == FP_WAIT) begin
            if (uop_src_use_i[0] && uop_src1_i == fp_dst) hz_raw = 1'b1;
            if (uop_src_use_i[1] && uop_src2_i == fp_dst) hz_raw = 1'b1;
            if (uop_dst_i == fp_dst) hz_waw = 1'b1;
        end
        // a new entry lands in post-shift slot lat-1, i.e. current slot lat
        hz_struct = res_v[lat];
        hazard    = is_fp ? any_v : (hz_struct | hz_raw | hz_waw);
    end

    assign uop_ready_o = (state == RUN) & vex_ready_i & ~hazard & ~drain_req_i;
    assign accept      = uop_valid_i & uop_ready_o;
    assign vex_valid_o = accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_v <= '0;
            for (int k = 0; k <= MAX_LAT; k++) res_d[k] <= '0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                res_v[k] <= res_v[k+1];
                res_d[k] <= res_d[k+1];
            end
            res_v[MAX_LAT] <= 1'b0;
            res_d[MAX_LAT] <= '0;
            if (accept && !is_fp) begin
                res_v[slot] <= 1'b1;
                res_d[slot] <= uop_dst_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            fp_dst <= '0;
        end else begin
            state <= state_nxt;
            if (accept && is_fp) fp_dst <= uop_dst_i;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (accept && is_fp) state_nxt = FP_WAIT;
                else if (drain_req_i) state_nxt = DRAIN;
            end
            FP_WAIT: begin
                if (fp_done_i) state_nxt = drain_req_i ? DRAIN : RUN;
            end
            DRAIN: begin
                if (!any_v && vex_idle_i) state_nxt = DRAINED;
            end
            DRAINED: begin
                if (!drain_req_i) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        wb_valid_o = res_v[0];
        wb_addr_o  = res_v[0] ? res_d[0] : '0;
        if (state == FP_WAIT) begin
            wb_valid_o = fp_done_i;
            wb_addr_o  = fp_done_i ? fp_dst : '0;
        end
    end

    assign drain_ack_o = (state == DRAINED) & drain_req_i;
    assign busy_o      = any_v | (state == FP_WAIT);

endmodule
